// File: rtl/matrix_loader.sv
// matrix_loader: streams a row-major 3x3 Q4.12 matrix into the inversion
// core's register file, frames it with in_last, and starts the core once a
// complete matrix has been committed. New input is held off until done.
module matrix_loader #(
   parameter int WORDLEN        = 16,
   parameter int MATRIX_ROWS    = 3,
   parameter int MATRIX_COLUMNS = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WORDLEN-1:0] in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic               wr_en,
   output logic [1:0]         wr_row,
   output logic [1:0]         wr_col,
   output logic [WORDLEN-1:0] wr_data,
   output logic               start,
   input  logic               done,
   output logic               err
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      START,
      WAIT
   } state_t;

   state_t     state;
   logic [1:0] row;
   logic [1:0] col;
   logic       last_pos;
   logic       xfer;

   // Accept elements only while loading; forced low while reset is held.
   always_comb begin
      in_ready = ((state == IDLE) || (state == LOAD)) && !RST;
      xfer     = in_valid && in_ready;
      last_pos = (row == 2'(MATRIX_ROWS - 1)) && (col == 2'(MATRIX_COLUMNS - 1));
   end

   // Load-path FSM with registered write strobe, start and error pulses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         row     <= '0;
         col     <= '0;
         wr_en   <= 1'b0;
         wr_row  <= '0;
         wr_col  <= '0;
         wr_data <= '0;
         start   <= 1'b0;
         err     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         start <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE, LOAD: begin
               if (xfer) begin
                  wr_en   <= 1'b1;
                  wr_row  <= row;
                  wr_col  <= col;
                  wr_data <= in_data;
                  if (last_pos && in_last) begin
                     state <= FLUSH;
                     row   <= '0;
                     col   <= '0;
                  end else if (last_pos || in_last) begin
                     // Badly framed: element is kept, frame is dropped.
                     err   <= 1'b1;
                     state <= IDLE;
                     row   <= '0;
                     col   <= '0;
                  end else begin
                     state <= LOAD;
                     if (col == 2'(MATRIX_COLUMNS - 1)) begin
                        col <= '0;
                        row <= row + 2'd1;
                     end else begin
                        col <= col + 2'd1;
                     end
                  end
               end
            end
            FLUSH: begin
               start <= 1'b1;
               state <= START;
            end
            START: begin
               // done coinciding with the start pulse belongs to an older run.
               state <= WAIT;
            end
            WAIT: begin
               if (done) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
